// File: rtl/idct8.sv
// 8-point 1-D inverse DCT (HEVC integer matrix, x64) using an even/odd partial butterfly.
// Four register levels: input capture, products, partial sums, and the rounded result.
module idct8 (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    input  logic [255:0] data_in,
    input  logic [4:0]   shift_amount,
    output logic [255:0] data_out,
    output logic         m_valid
);

    // Even rows (k = 0,2,4,6) and odd rows (k = 1,3,5,7), columns n = 0..3 only;
    // columns 4..7 come from the butterfly symmetry.
    localparam int C_EVEN [4][4] = '{'{64,  64,  64,  64},
                                     '{83,  36, -36, -83},
                                     '{64, -64, -64,  64},
                                     '{36, -83,  83, -36}};
    localparam int C_ODD  [4][4] = '{'{89,  75,  50,  18},
                                     '{75, -18, -89, -50},
                                     '{50, -89,  18,  75},
                                     '{18, -50,  75, -89}};

    logic [255:0]       x_q;
    logic [4:0]         sh1_q, sh2_q, sh3_q;
    logic               v1_q, v2_q, v3_q, mv_q;
    logic signed [47:0] pe_d [4][4];
    logic signed [47:0] po_d [4][4];
    logic signed [47:0] pe_q [4][4];
    logic signed [47:0] po_q [4][4];
    logic signed [47:0] e_d [4];
    logic signed [47:0] o_d [4];
    logic signed [47:0] e_q [4];
    logic signed [47:0] o_q [4];
    logic [255:0]       dout_d, dout_q;

    // Rounding arithmetic right shift; the result wraps to 32 bits by design.
    function automatic logic [31:0] round_shift(input logic signed [47:0] v, input logic [4:0] s);
        logic signed [47:0] ofs;
        ofs = (s == 5'd0) ? 48'sd0 : (48'sd1 <<< (s - 5'd1));
        return 32'((v + ofs) >>> s);
    endfunction

    // NOTE: only the valid bits and the visible outputs take reset; the datapath
    // registers are qualified by valid, so clearing them would only cost routing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= s_valid;
            if (s_valid) begin
                x_q   <= data_in;
                sh1_q <= shift_amount;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            for (int n = 0; n < 4; n++) begin
                pe_d[j][n] = 48'($signed(x_q[64*j +: 32]))      * 48'(C_EVEN[j][n]);
                po_d[j][n] = 48'($signed(x_q[64*j + 32 +: 32])) * 48'(C_ODD[j][n]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                pe_q  <= pe_d;
                po_q  <= po_d;
                sh2_q <= sh1_q;
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            e_d[n] = 48'sd0;
            o_d[n] = 48'sd0;
            for (int j = 0; j < 4; j++) begin
                e_d[n] = e_d[n] + pe_q[j][n];
                o_d[n] = o_d[n] + po_q[j][n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v3_q <= 1'b0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                e_q   <= e_d;
                o_q   <= o_d;
                sh3_q <= sh2_q;
            end
        end
    end

    always_comb begin
        dout_d = '0;
        for (int n = 0; n < 4; n++) begin
            dout_d[32*n +: 32]     = round_shift(e_q[n] + o_q[n], sh3_q);
            dout_d[32*(7-n) +: 32] = round_shift(e_q[n] - o_q[n], sh3_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mv_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            mv_q <= v3_q;
            if (v3_q) begin
                dout_q <= dout_d;
            end
        end
    end

    assign data_out = dout_q;
    assign m_valid  = mv_q;

endmodule

// File: tb/tb_idct8.sv
// Directed self-checking bench for idct8: reset, matrix rows, rounding, streaming, mid-flight reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_idct8;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic [255:0] data_in;
    logic [4:0]   shift_amount;
    logic [255:0] data_out;
    logic         m_valid;

    int total = 0;
    int bad   = 0;
    int xv [8];
    int ev [8];
    int ea [8];
    int eb [8];
    int ec [8];

    localparam int C [8][8] = '{'{64,  64,  64,  64,  64,  64,  64,  64},
                                '{89,  75,  50,  18, -18, -50, -75, -89},
                                '{83,  36, -36, -83, -83, -36,  36,  83},
                                '{75, -18, -89, -50,  50,  89,  18, -75},
                                '{64, -64, -64,  64,  64, -64, -64,  64},
                                '{50, -89,  18,  75, -75, -18,  89, -50},
                                '{36, -83,  83, -36, -36,  83, -83,  36},
                                '{18, -50,  75, -89,  89, -75,  50, -18}};

    idct8 dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .data_in      (data_in),
        .shift_amount (shift_amount),
        .data_out     (data_out),
        .m_valid      (m_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic set_x(input int v0, input int v1, input int v2, input int v3,
                         input int v4, input int v5, input int v6, input int v7);
        xv[0] = v0; xv[1] = v1; xv[2] = v2; xv[3] = v3;
        xv[4] = v4; xv[5] = v5; xv[6] = v6; xv[7] = v7;
    endtask

    task automatic drive_vec(input int sh);
        for (int k = 0; k < 8; k++) data_in[32*k +: 32] = xv[k];
        shift_amount = 5'(sh);
        s_valid      = 1'b1;
    endtask

    task automatic drive_idle();
        s_valid      = 1'b0;
        data_in      = {8{$urandom}};
        shift_amount = 5'($urandom);
    endtask

    task automatic chk_lanes(input string tag, input int e [8]);
        for (int n = 0; n < 8; n++)
            chk($sformatf("%s_x%0d", tag, n), data_out[32*n +: 32], 32'(e[n]));
    endtask

    // One vector captured at edge T; result expected after edge T+3, then held.
    task automatic run_vec(input string tag, input int sh);
        @(negedge clk);
        drive_vec(sh);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_early"}, 32'(m_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_mv"}, 32'(m_valid), 32'd1);
        chk_lanes(tag, ev);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(m_valid), 32'd0);
        chk({tag, "_hold"}, data_out[31:0], 32'(ev[0]));
    endtask

    initial begin
        // Reset held with s_valid high: nothing may be accepted.
        rst = 1'b0;
        set_x(7, 7, 7, 7, 7, 7, 7, 7);
        drive_vec(0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drive_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("reset_mv%0d", i), 32'(m_valid), 32'd0);
            chk($sformatf("reset_dout%0d", i), {31'd0, |data_out}, 32'd0);
        end

        set_x(100, 100, 100, 100, 100, 100, 100, 100);
        ev = '{23, -6, 5, -2, 3, 0, 2, 1};
        run_vec("all100_s11", 11);

        set_x(100, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 8; n++) ev[n] = 3;
        run_vec("dc_s11", 11);
        for (int n = 0; n < 8; n++) ev[n] = 6400;
        run_vec("dc_s0", 0);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 8; i++) xv[i] = (i == k) ? 1 : 0;
            for (int n = 0; n < 8; n++) ev[n] = C[k][n];
            run_vec($sformatf("imp%0d", k), 0);
        end

        set_x(-100, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 8; n++) ev[n] = -3;
        run_vec("neg100_s11", 11);
        set_x(-32, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 8; n++) ev[n] = -1;
        run_vec("neg32_s11", 11);

        // Back-to-back: three vectors with shifts 0, 7, 11.
        for (int n = 0; n < 8; n++) ea[n] = 6400;
        eb = '{89, 75, 50, 18, -18, -50, -75, -89};
        ec = '{23, -6, 5, -2, 3, 0, 2, 1};
        @(negedge clk);
        set_x(100, 0, 0, 0, 0, 0, 0, 0);
        drive_vec(0);
        @(negedge clk);
        set_x(0, 128, 0, 0, 0, 0, 0, 0);
        drive_vec(7);
        @(negedge clk);
        set_x(100, 100, 100, 100, 100, 100, 100, 100);
        drive_vec(11);
        @(negedge clk);
        drive_idle();
        chk("b2b_early", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("b2b_mv0", 32'(m_valid), 32'd1);
        chk_lanes("b2b_a", ea);
        @(negedge clk);
        chk("b2b_mv1", 32'(m_valid), 32'd1);
        chk_lanes("b2b_b", eb);
        @(negedge clk);
        chk("b2b_mv2", 32'(m_valid), 32'd1);
        chk_lanes("b2b_c", ec);
        @(negedge clk);
        chk("b2b_end", 32'(m_valid), 32'd0);

        // Idle cycles with junk on the inputs must leave the outputs untouched.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_idle();
            chk($sformatf("idle_mv%0d", i), 32'(m_valid), 32'd0);
            chk($sformatf("idle_hold%0d", i), data_out[32*7 +: 32], 32'(ec[7]));
        end

        // Reset one cycle after acceptance discards the vector.
        @(negedge clk);
        set_x(100, 0, 0, 0, 0, 0, 0, 0);
        drive_vec(0);
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_mv%0d", i), 32'(m_valid), 32'd0);
            chk($sformatf("midrst_dout%0d", i), {31'd0, |data_out}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
